// File: rtl/dmem_resp_if.sv
// Load/store request and single-pulse response bus between the datapath
// memory port (master) and the data-memory responder (slave).
interface dmem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_resp.sv
// Multi-cycle data-memory responder: accepts one word load/store, waits
// LATENCY cycles, performs the access and returns a one-cycle response.
module dmem_resp #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  dmem_resp_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        ready_c;
  logic        valid_c;
  logic        accept;
  logic        do_access;

  logic [31:0] mem [DEPTH];

  // NOTE: every always_comb output is defaulted first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    ready_c    = 1'b0;
    valid_c    = 1'b0;
    accept     = 1'b0;
    do_access  = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.req_valid) begin
          accept     = 1'b1;
          next_state = (LATENCY == 0) ? RESP : WAIT;
          do_access  = (LATENCY == 0);
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          next_state = RESP;
          do_access  = 1'b1;
        end
      end
      RESP: begin
        valid_c    = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign bus.req_ready  = ready_c;
  assign bus.resp_valid = valid_c;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  // With zero wait states the access happens on the accepting edge, so it
  // must use the live request fields rather than the not-yet-latched copy.
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_err;
  logic [AW-1:0] acc_idx;

  assign acc_we    = (LATENCY == 0) ? bus.req_we    : lat_we;
  assign acc_addr  = (LATENCY == 0) ? bus.req_addr  : lat_addr;
  assign acc_wdata = (LATENCY == 0) ? bus.req_wdata : lat_wdata;
  assign acc_err   = (acc_addr[1:0] != 2'b00) ||
                     ({2'b00, acc_addr[31:2]} >= 32'(DEPTH));
  assign acc_idx   = acc_addr[AW+1:2];

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        cnt       <= 4'(LATENCY);
        lat_we    <= bus.req_we;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end

      if (do_access) begin
        err_q   <= acc_err;
        rdata_q <= (acc_err || acc_we) ? 32'd0 : mem[acc_idx];
      end else if (state == RESP) begin
        err_q   <= 1'b0;
        rdata_q <= 32'd0;
      end
    end
  end

  // NOTE: the array has no reset branch; its contents survive reset and it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (!reset && do_access && acc_we && !acc_err) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Directed self-checking bench for dmem_resp with LATENCY = 2 and LATENCY = 0
// instances sharing clock and reset.
module tb_dmem_resp;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  dmem_resp_if b2 ();
  dmem_resp_if b0 ();

  dmem_resp #(.DEPTH(64), .LATENCY(2)) u_lat2 (.clk(clk), .reset(reset), .bus(b2.slave));
  dmem_resp #(.DEPTH(64), .LATENCY(0)) u_lat0 (.clk(clk), .reset(reset), .bus(b0.slave));

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One LATENCY=2 transaction, issued at a negedge in IDLE, checked cycle by cycle.
  task automatic txn2(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input string tag, input bit garble);
    b2.req_valid = 1'b1;
    b2.req_we    = we;
    b2.req_addr  = addr;
    b2.req_wdata = wdata;
    check({tag, ".ready_c0"}, b2.req_ready, 32'd1);
    step();
    b2.req_valid = 1'b0;
    if (garble) begin
      b2.req_we    = 1'b1;
      b2.req_addr  = 32'h0000_0008;
      b2.req_wdata = 32'hBAD0_BAD0;
    end
    check({tag, ".ready_c1"}, b2.req_ready, 32'd0);
    check({tag, ".valid_c1"}, b2.resp_valid, 32'd0);
    step();
    check({tag, ".ready_c2"}, b2.req_ready, 32'd0);
    check({tag, ".valid_c2"}, b2.resp_valid, 32'd0);
    step();
    check({tag, ".valid_c3"}, b2.resp_valid, 32'd1);
    check({tag, ".ready_c3"}, b2.req_ready, 32'd0);
    check({tag, ".rdata_c3"}, b2.resp_rdata, exp_rdata);
    check({tag, ".err_c3"}, b2.resp_err, 32'(exp_err));
    step();
    check({tag, ".valid_c4"}, b2.resp_valid, 32'd0);
    check({tag, ".ready_c4"}, b2.req_ready, 32'd1);
    check({tag, ".rdata_c4"}, b2.resp_rdata, 32'd0);
    check({tag, ".err_c4"}, b2.resp_err, 32'd0);
  endtask

  initial begin
    b2.req_valid = 1'b0; b2.req_we = 1'b0; b2.req_addr = 32'd0; b2.req_wdata = 32'd0;
    b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_addr = 32'd0; b0.req_wdata = 32'd0;

    // Reset and idle
    step();
    check("rst.ready", b2.req_ready, 32'd1);
    check("rst.valid", b2.resp_valid, 32'd0);
    check("rst.rdata", b2.resp_rdata, 32'd0);
    check("rst.err", b2.resp_err, 32'd0);
    reset = 1'b0;
    step();
    check("idle.ready", b2.req_ready, 32'd1);
    check("idle.valid", b2.resp_valid, 32'd0);
    check("idle0.ready", b0.req_ready, 32'd1);
    check("idle0.valid", b0.resp_valid, 32'd0);

    // Basic store / load
    txn2(1'b1, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0, "st10", 1'b0);
    txn2(1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, "ld10", 1'b0);

    // Error cases and aliasing
    txn2(1'b1, 32'h0, 32'hCAFE_F00D, 32'd0, 1'b0, "st00", 1'b0);
    txn2(1'b0, 32'h13, 32'd0, 32'd0, 1'b1, "ld13mis", 1'b0);
    txn2(1'b1, 32'h100, 32'h1234, 32'd0, 1'b1, "st100oor", 1'b0);
    txn2(1'b1, 32'h4000_0000, 32'h1234, 32'd0, 1'b1, "stwrap", 1'b0);
    txn2(1'b0, 32'h0, 32'd0, 32'hCAFE_F00D, 1'b0, "ld00", 1'b0);

    // Highest legal word
    txn2(1'b1, 32'hFC, 32'h3F3F_3F3F, 32'd0, 1'b0, "stFC", 1'b0);
    txn2(1'b0, 32'hFC, 32'd0, 32'h3F3F_3F3F, 1'b0, "ldFC", 1'b0);

    // Request fields changed after acceptance
    txn2(1'b1, 32'h4, 32'h1111_1111, 32'd0, 1'b0, "st04", 1'b0);
    txn2(1'b1, 32'h8, 32'h2222_2222, 32'd0, 1'b0, "st08", 1'b0);
    txn2(1'b0, 32'h4, 32'd0, 32'h1111_1111, 1'b0, "ld04garble", 1'b1);
    txn2(1'b0, 32'h8, 32'd0, 32'h2222_2222, 1'b0, "ld08after", 1'b0);

    // Reset during WAIT of a store
    txn2(1'b1, 32'h20, 32'h5A5A_0000, 32'd0, 1'b0, "st20pre", 1'b0);
    b2.req_valid = 1'b1; b2.req_we = 1'b1; b2.req_addr = 32'h20; b2.req_wdata = 32'hA5A5_A5A5;
    step();
    b2.req_valid = 1'b0;
    check("rstwait.ready_pre", b2.req_ready, 32'd0);
    #2 reset = 1'b1;
    #1;
    check("rstwait.ready_async", b2.req_ready, 32'd1);
    check("rstwait.valid_async", b2.resp_valid, 32'd0);
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rstwait.novalid%0d", i), b2.resp_valid, 32'd0);
      check($sformatf("rstwait.ready%0d", i), b2.req_ready, 32'd1);
      step();
    end
    txn2(1'b0, 32'h20, 32'd0, 32'h5A5A_0000, 1'b0, "ld20post", 1'b0);

    // Reset during RESP clears registered outputs without a clock edge
    b2.req_valid = 1'b1; b2.req_we = 1'b0; b2.req_addr = 32'h10;
    step();
    b2.req_valid = 1'b0;
    step();
    step();
    check("rstresp.valid_pre", b2.resp_valid, 32'd1);
    check("rstresp.rdata_pre", b2.resp_rdata, 32'hDEAD_BEEF);
    #2 reset = 1'b1;
    #1;
    check("rstresp.valid_async", b2.resp_valid, 32'd0);
    check("rstresp.rdata_async", b2.resp_rdata, 32'd0);
    check("rstresp.err_async", b2.resp_err, 32'd0);
    check("rstresp.ready_async", b2.req_ready, 32'd1);
    step();
    reset = 1'b0;
    step();

    // LATENCY = 0, back-to-back with req_valid held high
    b0.req_valid = 1'b1; b0.req_we = 1'b1; b0.req_addr = 32'h40; b0.req_wdata = 32'h600D_CAFE;
    check("l0.ready_c0", b0.req_ready, 32'd1);
    step();
    check("l0.st_valid", b0.resp_valid, 32'd1);
    check("l0.st_err", b0.resp_err, 32'd0);
    check("l0.st_rdata", b0.resp_rdata, 32'd0);
    check("l0.st_ready", b0.req_ready, 32'd0);
    b0.req_we = 1'b0; b0.req_addr = 32'h40; b0.req_wdata = 32'd0;
    step();
    check("l0.gap1_valid", b0.resp_valid, 32'd0);
    check("l0.gap1_ready", b0.req_ready, 32'd1);
    step();
    check("l0.ld_valid", b0.resp_valid, 32'd1);
    check("l0.ld_rdata", b0.resp_rdata, 32'h600D_CAFE);
    check("l0.ld_err", b0.resp_err, 32'd0);
    b0.req_we = 1'b0; b0.req_addr = 32'h41;
    step();
    check("l0.gap2_valid", b0.resp_valid, 32'd0);
    check("l0.gap2_ready", b0.req_ready, 32'd1);
    step();
    check("l0.mis_valid", b0.resp_valid, 32'd1);
    check("l0.mis_err", b0.resp_err, 32'd1);
    check("l0.mis_rdata", b0.resp_rdata, 32'd0);
    b0.req_valid = 1'b0;
    step();
    check("l0.end_valid", b0.resp_valid, 32'd0);
    check("l0.end_ready", b0.req_ready, 32'd1);
    check("l0.end_err", b0.resp_err, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Multi-cycle data-memory responder: the memory-side end of the processor's load/store interface. It accepts one word-sized read or write request per transaction through a valid/ready handshake, waits a configurable number of wait states, and then returns exactly one response pulse carrying read data or an error flag. It sits between the datapath's memory port (address from the ALU result, store data from the register file's second read port) and the word-organised data memory array it owns.

## Interface
- DEPTH, 64: number of 32-bit words in the array; valid word indices 0..DEPTH-1.
- LATENCY, 2: wait-state cycles between request acceptance and response; legal range 0..15.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store word, 0 = load word.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- resp_valid  output  1  one-cycle response strobe.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  valid only with resp_valid; 1 = misaligned or out-of-range access.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state: IDLE.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready: latch we, addr and wdata, then load the wait counter with LATENCY.
  - Go to WAIT if LATENCY > 0; otherwise go directly to RESP.
- WAIT:
  - req_ready = 0. The counter decrements each cycle.
  - On the edge where the counter reaches 1 → RESP.
  - The access is performed on that same transition edge.
- Access rules:
  - Error if latched addr[1:0] != 0 or addr[31:2] >= DEPTH, using the full 30-bit compare with no truncation or wrap-around.
  - On error: no write; resp_rdata = 0; resp_err = 1.
  - Good store: mem[addr[31:2]] <= wdata; resp_rdata = 0; resp_err = 0.
  - Good load: resp_rdata = mem[addr[31:2]]; resp_err = 0.
- RESP:
  - resp_valid = 1 for exactly one cycle; req_ready = 0; then → IDLE.
  - There is no response backpressure. The consumer must sample resp_valid in that cycle.
- Inputs are ignored while not in IDLE. Changes to req_* after acceptance have no effect on the transaction.
- A store followed by a load to the same word returns the stored value.
- Array contents are not initialised by reset and are unaffected by it.

## Timing
- Reset values, asserted asynchronously: state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, wait counter = 0, latched request = 0.
- Let edge E0 be the accepting edge.
  - resp_valid is high during the cycle after edge E0+LATENCY+1 edges... precisely, it is high in cycle LATENCY+1, counting the cycle after E0 as cycle 1.
  - With LATENCY = 0, resp_valid is high in the cycle immediately after acceptance.
- req_ready returns to 1 in the cycle after the response cycle.
  - Maximum throughput is one transaction per LATENCY+2 cycles.
- resp_rdata and resp_err are registered. They hold their values only during the resp_valid cycle and return to 0 afterwards.
- Reset mid-transaction, in WAIT or RESP:
  - The transaction is dropped.
  - A pending store is not performed, provided reset asserts before its write edge.
  - No response is produced, and the FSM restarts in IDLE.
- req_valid held high through RESP: the next request is accepted on the first IDLE edge, not earlier.

## Test plan
- Reset, then idle: req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0. Assert reset mid-cycle and check that the outputs clear without a clock edge.
- LATENCY = 2:
  - Store 0xDEADBEEF to address 0x10, accepted at E0. resp_valid must be high exactly in cycle 3, with resp_err = 0 and resp_rdata = 0, and req_ready = 0 in cycles 1–3.
  - Then load 0x10: resp_rdata = 0xDEADBEEF.
- Error cases, LATENCY = 2, DEPTH = 64:
  - Load from 0x13 (misaligned) → resp_err = 1, rdata = 0.
  - Store 0x1234 to 0x100 (index 64) → resp_err = 1.
  - A follow-up load from 0x0 must show that word 0 is unchanged, i.e. no aliasing.
- LATENCY = 0: back-to-back requests with req_valid held high. Transactions are accepted every 2 cycles, resp_valid pulses every 2 cycles, and the load returns the word stored by the prior store.
- Reset during WAIT of a store of 0xA5A5A5A5 to 0x20:
  - No resp_valid is produced, and req_ready = 1 after reset.
  - A subsequent load of 0x20 returns the pre-existing value, not 0xA5A5A5A5.
- Request fields changed during WAIT, e.g. addr changed from 0x04 to 0x08: the response reflects the latched 0x04 access only.
